// File: rtl/javk_mem_pkg.sv
// javk_mem_pkg: shared definitions for the JAVK memory/IO responder.
//   - IO register offsets relative to IO_BASE
//   - STATUS register layout and bit positions
//   - responder state encodings
package javk_mem_pkg;

  // IO register offsets from IO_BASE
  localparam logic [15:0] IO_TXDATA = 16'd0;
  localparam logic [15:0] IO_STATUS = 16'd1;

  // STATUS bit positions
  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_OVF   = 2;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // STATUS register image; field order matches the STAT_* positions
  typedef struct packed {
    logic [4:0] rsvd;
    logic       ovf;
    logic       full;
    logic       empty;
  } status_t;

  function automatic logic [7:0] status_byte(input logic ovf, input logic full,
                                             input logic empty);
    status_t s;
    s       = '0;
    s.ovf   = ovf;
    s.full  = full;
    s.empty = empty;
    return s;
  endfunction

endpackage

// File: rtl/javk_mem_if.sv
// javk_mem_if: CPU address/direction plus the loader and transmit streams
// of javk_mem.
//   addrbus/rw           : CPU address and direction (1 = CPU write)
//   ld_valid/ld_data/ld_last/ld_ready : boot-loader byte stream into RAM
//   tx_valid/tx_data/tx_ready         : transmit FIFO head to consumer
// The 8-bit bidirectional databus stays a plain inout on the block.
interface javk_mem_if;
  logic [15:0] addrbus;
  logic        rw;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport slave (
    input  addrbus, rw, ld_valid, ld_data, ld_last, tx_ready,
    output ld_ready, tx_valid, tx_data
  );

  modport master (
    output addrbus, rw, ld_valid, ld_data, ld_last, tx_ready,
    input  ld_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/javk_fifo.sv
// javk_fifo: single-clock synchronous FIFO.
//   clk, rst   : clock, synchronous active-high flush
//   push/din   : write request and data (ignored while full unless popping)
//   pop        : read request (ignored while empty)
//   head       : entry at the read pointer
//   full/empty : derived from an occupancy count
module javk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             do_push, do_pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the slot the push needs, so full+push+pop is legal.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/javk_mem.sv
// javk_mem: memory/IO responder on the JAVK CPU bus.
//   clk, rst : clock, synchronous active-high reset
//   databus  : 8-bit CPU data bus; driven only on RUN-state reads
//   cpu_rst  : registered reset to the CPU (high in LOAD and HOLD)
//   bus      : addrbus/rw, loader stream (ld_*), transmit stream (tx_*)
// Map: RAM at 0..RAM_DEPTH-1, TXDATA at IO_BASE+0, STATUS at IO_BASE+1.
module javk_mem
  import javk_mem_pkg::*;
#(
  parameter int          RAM_DEPTH  = 4096,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] databus,
  output logic       cpu_rst,
  javk_mem_if.slave  bus
);
  localparam int AW = $clog2(RAM_DEPTH);

  state_e        state;
  logic [AW-1:0] ld_ptr;
  logic          hold_cnt;
  logic          ovf;
  logic [7:0]    ram [RAM_DEPTH];

  logic          run, ld_fire;
  logic          in_ram, is_tx, is_stat;
  logic          push, pop, drop, ovf_clr;
  logic          full, empty;
  logic [7:0]    head, rd_data;

  assign run     = (state == RUN);
  assign ld_fire = bus.ld_valid && bus.ld_ready;

  // Address decode straight from addrbus so the read path never depends
  // on databus.
  assign in_ram  = (bus.addrbus < 16'(RAM_DEPTH));
  assign is_tx   = (bus.addrbus == IO_BASE + IO_TXDATA);
  assign is_stat = (bus.addrbus == IO_BASE + IO_STATUS);

  assign push    = run && bus.rw && is_tx;
  assign pop     = bus.tx_valid && bus.tx_ready;
  assign drop    = push && full && !pop;
  assign ovf_clr = run && bus.rw && is_stat;

  // Sequencer: LOAD fills RAM, HOLD keeps the CPU in reset for two more
  // cycles, RUN opens the bus. Only rst leaves RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      ld_ptr       <= '0;
      hold_cnt     <= 1'b0;
      cpu_rst      <= 1'b1;
      bus.ld_ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          cpu_rst      <= 1'b1;
          bus.ld_ready <= 1'b1;
          if (ld_fire) begin
            ld_ptr <= ld_ptr + 1'b1;
            if (bus.ld_last || ld_ptr == AW'(RAM_DEPTH-1)) begin
              state        <= HOLD;
              hold_cnt     <= 1'b0;
              bus.ld_ready <= 1'b0;
            end
          end
        end
        HOLD: begin
          bus.ld_ready <= 1'b0;
          if (hold_cnt) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else begin
            hold_cnt <= 1'b1;
            cpu_rst  <= 1'b1;
          end
        end
        RUN: begin
          cpu_rst      <= 1'b0;
          bus.ld_ready <= 1'b0;
        end
        default: begin
          state        <= LOAD;
          cpu_rst      <= 1'b1;
          bus.ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // RAM has no reset; loader and CPU writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_fire && state == LOAD)
        ram[ld_ptr] <= bus.ld_data;
      else if (run && bus.rw && in_ram)
        ram[bus.addrbus[AW-1:0]] <= databus;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  javk_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (databus),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = head;

  always_comb begin
    rd_data = 8'h00;
    if (in_ram)       rd_data = ram[bus.addrbus[AW-1:0]];
    else if (is_stat) rd_data = status_byte(ovf, full, empty);
  end

  assign databus = (run && !bus.rw) ? rd_data : 8'bz;
endmodule
